// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin burst arbiter.
// Latency: none (types and pure functions only).
// Backpressure: not applicable.
package arb_pkg;

    // Widest requester vector the helper functions handle; N must not exceed it.
    localparam int ARB_MAX_N = 32;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_e;

    typedef logic [ARB_MAX_N-1:0] arb_vec_t;

    // Thermometer mask selecting requesters at or above the priority pointer.
    function automatic arb_vec_t rr_mask(input int unsigned ptr);
        arb_vec_t m;
        for (int unsigned i = 0; i < ARB_MAX_N; i++) begin
            m[i] = (i >= ptr);
        end
        return m;
    endfunction

    // Index of the set bit in a one-hot (or zero) vector; zero maps to 0.
    function automatic int unsigned onehot2idx(input arb_vec_t oh);
        int unsigned idx;
        idx = 0;
        for (int unsigned i = 0; i < ARB_MAX_N; i++) begin
            if (oh[i]) begin
                idx = idx | i;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/fixed_priority_arbiter.sv
// Fixed-priority picker: lowest set request bit wins.
// Latency: purely combinational.
// Backpressure: none; output follows req every cycle.
// Ports: req (WIDTH requests in), gnt (one-hot or zero grant out).
module fixed_priority_arbiter #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] req,
    output logic [WIDTH-1:0] gnt
);

    // Two's-complement trick isolates the lowest set bit.
    assign gnt = req & (~req + WIDTH'(1));

endmodule

// File: rtl/rr_burst_arbiter.sv
// Round-robin arbiter granting one requester a whole burst of len+1 beats.
// Latency: request at edge t -> registered grant after edge t+1; one idle cycle between bursts.
// Backpressure: res_ready low stalls the burst count; grant is held through stalls.
// Ports: clk, rst_n; req[N], req_len[N*LEN_W] (sampled at grant), res_ready;
//        grant[N] one-hot, grant_vld, grant_idx, beat, beat_last.
module rr_burst_arbiter
    import arb_pkg::*;
#(
    parameter int N     = 4,
    parameter int LEN_W = 4,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N-1:0]       req,
    input  logic [N*LEN_W-1:0] req_len,
    input  logic               res_ready,
    output logic [N-1:0]       grant,
    output logic               grant_vld,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               beat,
    output logic               beat_last
);

    arb_state_e       state, state_nxt;
    logic [IDX_W-1:0] ptr, ptr_nxt, grant_idx_nxt, win_idx, idx_inc;
    logic [N-1:0]     grant_nxt, req_masked, gnt_masked, gnt_raw, win_oh;
    logic [LEN_W-1:0] cnt, cnt_nxt, win_len;
    logic             cur_req, release_burst;

    // Masked pick gives round-robin order; raw pick handles wrap-around.
    assign req_masked = N'(arb_vec_t'(req) & rr_mask(32'(ptr)));

    fixed_priority_arbiter #(.WIDTH(N)) u_fpa_masked (
        .req (req_masked),
        .gnt (gnt_masked)
    );

    fixed_priority_arbiter #(.WIDTH(N)) u_fpa_raw (
        .req (req),
        .gnt (gnt_raw)
    );

    assign win_oh  = (|gnt_masked) ? gnt_masked : gnt_raw;
    assign win_idx = IDX_W'(onehot2idx(arb_vec_t'(win_oh)));
    assign win_len = req_len[win_idx*LEN_W +: LEN_W];

    assign cur_req       = req[grant_idx];
    assign grant_vld     = |grant;
    assign beat          = grant_vld & res_ready & cur_req;
    assign beat_last     = beat & (cnt == '0);
    // Dropping the request mid-burst releases exactly like a last beat.
    assign release_burst = (state == ARB_BUSY) & (beat_last | ~cur_req);

    // Explicit compare keeps non-power-of-two N from indexing past N-1.
    assign idx_inc = (grant_idx == IDX_W'(N - 1)) ? '0 : grant_idx + IDX_W'(1);

    // State register plus the burst datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ARB_IDLE;
            grant     <= '0;
            grant_idx <= '0;
            ptr       <= '0;
            cnt       <= '0;
        end else begin
            state     <= state_nxt;
            grant     <= grant_nxt;
            grant_idx <= grant_idx_nxt;
            ptr       <= ptr_nxt;
            cnt       <= cnt_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            ARB_IDLE: if (|req) state_nxt = ARB_BUSY;
            ARB_BUSY: if (release_burst) state_nxt = ARB_IDLE;
            default:  state_nxt = ARB_IDLE;
        endcase
    end

    // Next values of the registered outputs and burst counter.
    always_comb begin
        grant_nxt     = grant;
        grant_idx_nxt = grant_idx;
        ptr_nxt       = ptr;
        cnt_nxt       = cnt;
        case (state)
            ARB_IDLE: begin
                if (|req) begin
                    grant_nxt     = win_oh;
                    grant_idx_nxt = win_idx;
                    cnt_nxt       = win_len;
                end
            end
            ARB_BUSY: begin
                if (release_burst) begin
                    grant_nxt     = '0;
                    grant_idx_nxt = '0;
                    ptr_nxt       = idx_inc;
                end else if (beat) begin
                    cnt_nxt = cnt - LEN_W'(1);
                end
            end
            default: begin
                grant_nxt     = '0;
                grant_idx_nxt = '0;
            end
        endcase
    end

`ifndef SYNTHESIS
    a_grant_onehot0 : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(grant));
`endif

endmodule

// File: tb/tb_rr_burst_arbiter.sv
// Self-checking bench for rr_burst_arbiter: directed scenarios plus random traffic.
// Latency: n/a (testbench).
// Backpressure: res_ready driven directly and randomly.
module tb_rr_burst_arbiter;

    localparam int N     = 4;
    localparam int LEN_W = 4;

    logic               clk;
    logic               rst_n;
    logic [N-1:0]       req;
    logic [N*LEN_W-1:0] req_len;
    logic               res_ready;
    logic [N-1:0]       grant;
    logic               grant_vld;
    logic [1:0]         grant_idx;
    logic               beat;
    logic               beat_last;

    rr_burst_arbiter #(.N(N), .LEN_W(LEN_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .req_len   (req_len),
        .res_ready (res_ready),
        .grant     (grant),
        .grant_vld (grant_vld),
        .grant_idx (grant_idx),
        .beat      (beat),
        .beat_last (beat_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int n_last_seen = 0;
    int n_beat_seen = 0;

    // Reference model: who owns the resource, beats left, next-priority requester.
    int m_owner = -1;
    int m_rem   = 0;
    int m_ptr   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_len(input int i, input int v);
        req_len[i*LEN_W +: LEN_W] = LEN_W'(v);
    endtask

    function automatic int len_of(input int i);
        return int'(req_len[i*LEN_W +: LEN_W]);
    endfunction

    // Advance the model across one clock edge using the inputs the DUT sampled.
    task automatic model_update();
        int found;
        if (m_owner < 0) begin
            if (req != '0) begin
                found = -1;
                for (int k = 0; k < N; k++) begin
                    if (found < 0 && req[(m_ptr + k) % N]) found = (m_ptr + k) % N;
                end
                m_owner = found;
                m_rem   = len_of(found) + 1;
            end
        end else begin
            if (!req[m_owner]) begin
                m_ptr   = (m_owner + 1) % N;
                m_owner = -1;
            end else if (res_ready) begin
                m_rem--;
                if (m_rem == 0) begin
                    m_ptr   = (m_owner + 1) % N;
                    m_owner = -1;
                end
            end
        end
    endtask

    // Entered at posedge+1; checks combinational outputs mid-cycle, then registered ones after the edge.
    task automatic step();
        logic exp_beat, exp_last;
        @(negedge clk);
        exp_beat = 1'b0;
        if (m_owner >= 0) exp_beat = res_ready && req[m_owner];
        exp_last = exp_beat && (m_rem == 1);
        check_eq("beat", 32'(beat), 32'(exp_beat));
        check_eq("beat_last", 32'(beat_last), 32'(exp_last));
        if (beat_last) n_last_seen++;
        if (beat) n_beat_seen++;
        @(posedge clk);
        model_update();
        #1;
        check_eq("grant", 32'(grant), (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
        check_eq("grant_vld", 32'(grant_vld), 32'(m_owner >= 0));
        check_eq("grant_idx", 32'(grant_idx), (m_owner >= 0) ? 32'(m_owner) : 32'd0);
    endtask

    // Asserts reset between edges (entered at posedge+1) and checks outputs drop at once.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check_eq("rst_grant", 32'(grant), 32'd0);
        check_eq("rst_grant_vld", 32'(grant_vld), 32'd0);
        check_eq("rst_grant_idx", 32'(grant_idx), 32'd0);
        check_eq("rst_beat", 32'(beat), 32'd0);
        m_owner = -1;
        m_rem   = 0;
        m_ptr   = 0;
        #2;
        rst_n = 1'b1;
    endtask

    logic [N-1:0] rr_exp [9] = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100,
                                 4'b0000, 4'b1000, 4'b0000, 4'b0001};
    logic         bp_rdy [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [N-1:0] bp_exp [5] = '{4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0000};

    initial begin
        int n_on, last0, beat0;
        rst_n     = 1'b0;
        req       = 4'b1111;
        req_len   = '0;
        res_ready = 1'b0;
        @(posedge clk);
        #1;

        // Reset with all requesting, then first grant goes to requester 0.
        do_reset();
        step();
        check_eq("rst_first_grant", 32'(grant), 32'h1);

        // Burst of 4 beats for requester 1.
        req = '0;
        do_reset();
        req = 4'b0010;
        set_len(1, 3);
        res_ready = 1'b1;
        n_on  = 0;
        last0 = n_last_seen;
        beat0 = n_beat_seen;
        repeat (5) begin
            step();
            if (grant == 4'b0010) n_on++;
        end
        check_eq("burst_grant_cycles", 32'(n_on), 32'd4);
        check_eq("burst_beats", 32'(n_beat_seen - beat0), 32'd4);
        check_eq("burst_last_count", 32'(n_last_seen - last0), 32'd1);

        // Round robin with all requesting single-beat bursts.
        req = '0;
        do_reset();
        req_len   = '0;
        req       = 4'b1111;
        res_ready = 1'b1;
        for (int k = 0; k < 9; k++) begin
            step();
            check_eq($sformatf("rr_seq%0d", k), 32'(grant), 32'(rr_exp[k]));
        end

        // Backpressure: two-beat burst stretched by stalls.
        req = '0;
        do_reset();
        req_len   = '0;
        set_len(2, 1);
        req       = 4'b0100;
        res_ready = 1'b0;
        step();
        check_eq("bp_grant", 32'(grant), 32'h4);
        for (int k = 0; k < 5; k++) begin
            res_ready = bp_rdy[k];
            step();
            check_eq($sformatf("bp_hold%0d", k), 32'(grant), 32'(bp_exp[k]));
        end

        // Abort after two beats of an eight-beat burst; pointer wraps to 0.
        req = '0;
        do_reset();
        set_len(3, 7);
        req       = 4'b1000;
        res_ready = 1'b1;
        step();
        check_eq("abort_grant", 32'(grant), 32'h8);
        last0 = n_last_seen;
        step();
        step();
        req = 4'b0000;
        step();
        check_eq("abort_release", 32'(grant), 32'h0);
        check_eq("abort_no_last", 32'(n_last_seen - last0), 32'd0);
        req = 4'b1001;
        step();
        check_eq("abort_ptr_wrap", 32'(grant), 32'h1);

        // Asynchronous reset in the middle of a burst.
        req = '0;
        do_reset();
        set_len(1, 5);
        req       = 4'b0010;
        res_ready = 1'b1;
        step();
        step();
        check_eq("pre_rst_busy", 32'(grant), 32'h2);
        req = 4'b0100;
        do_reset();
        step();
        check_eq("post_rst_grant", 32'(grant), 32'h4);

        // Random traffic: sticky requests with occasional aborts and resets.
        for (int c = 0; c < 2000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!req[i]) req[i] = ($urandom_range(0, 2) == 0);
                else if ($urandom_range(0, 15) == 0) req[i] = 1'b0;
            end
            req_len   = N*LEN_W'($urandom);
            res_ready = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 299) == 0) do_reset();
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
